// File: rtl/alarm_ctrl_multi.sv
`timescale 1ns/1ps
// Multi-slot alarm controller: F1 walks the edit modes, F2 edits the selected slot or acknowledges a ring.
// Latency: every switch edge, MIN_TICK match and SEC_TICK takes effect at the next rising CLK edge.
// Backpressure: none; switch edges and tick pulses are consumed in the cycle they arrive.
module alarm_ctrl_multi #(
  parameter int NUM_ALM  = 4,
  parameter int IDXW     = 2,
  parameter int RST_HOUR = 7,
  parameter int RST_MIN  = 0,
  parameter int RING_SEC = 60
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SW_F1,
  input  logic                SW_F2,
  input  logic                SEC_TICK,
  input  logic                MIN_TICK,
  input  logic [4:0]          CUR_HOUR,
  input  logic [5:0]          CUR_MIN,
  output logic                ALM_SELECT,
  output logic                ALM_HOUR,
  output logic                ALM_MIN,
  output logic                ALM_ONOFF,
  output logic [IDXW-1:0]     ALM_IDX,
  output logic [4:0]          SET_HOUR,
  output logic [5:0]          SET_MIN,
  output logic [NUM_ALM-1:0]  ALM_EN,
  output logic                RING,
  output logic [IDXW-1:0]     RING_IDX
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEL   = 3'd1,
    S_HOUR  = 3'd2,
    S_MIN   = 3'd3,
    S_ONOFF = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         mode_q, mode_d;      // {select, hour, min, onoff}
  logic               f1_q, f2_q;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [4:0]         hour_q [NUM_ALM];
  logic [4:0]         hour_d [NUM_ALM];
  logic [5:0]         min_q  [NUM_ALM];
  logic [5:0]         min_d  [NUM_ALM];
  logic [NUM_ALM-1:0] en_q, en_d;
  logic               ring_q, ring_d;
  logic [IDXW-1:0]    ridx_q, ridx_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               f1e, f2e, f2_act;
  logic               hit;
  logic [IDXW-1:0]    hit_idx;
  logic               ack, dis_ring;

  // Next-state for mode FSM, slot edits and the ring/timeout logic.
  always_comb begin
    f1e     = SW_F1 & ~f1_q;
    f2e     = SW_F2 & ~f2_q;
    // A simultaneous F1 edge wins; the F2 edge is dropped.
    f2_act  = f2e & ~f1e;

    state_d = state_q;
    idx_d   = idx_q;
    hour_d  = hour_q;
    min_d   = min_q;
    en_d    = en_q;
    ring_d  = ring_q;
    ridx_d  = ridx_q;
    cnt_d   = cnt_q;
    mode_d  = 4'b0000;
    hit     = 1'b0;
    hit_idx = '0;

    if (f1e) begin
      case (state_q)
        S_IDLE:  state_d = S_SEL;
        S_SEL:   state_d = S_HOUR;
        S_HOUR:  state_d = S_MIN;
        S_MIN:   state_d = S_ONOFF;
        default: state_d = S_IDLE;
      endcase
    end

    if (f2_act) begin
      case (state_q)
        S_SEL: begin
          if (idx_q == IDXW'(NUM_ALM - 1)) idx_d = '0;
          else                             idx_d = idx_q + 1'b1;
        end
        S_HOUR: begin
          if (hour_q[idx_q] == 5'd23) hour_d[idx_q] = 5'd0;
          else                        hour_d[idx_q] = hour_q[idx_q] + 5'd1;
        end
        S_MIN: begin
          if (min_q[idx_q] == 6'd59) min_d[idx_q] = 6'd0;
          else                       min_d[idx_q] = min_q[idx_q] + 6'd1;
        end
        S_ONOFF: en_d[idx_q] = ~en_q[idx_q];
        default: ;
      endcase
    end

    // Scan high to low so the lowest matching slot ends up selected.
    for (int k = NUM_ALM - 1; k >= 0; k--) begin
      if (en_q[k] && (hour_q[k] == CUR_HOUR) && (min_q[k] == CUR_MIN)) begin
        hit     = 1'b1;
        hit_idx = IDXW'(k);
      end
    end

    ack      = f2_act && (state_q == S_IDLE) && ring_q;
    // Turning off the slot that is ringing silences it immediately.
    dis_ring = f2_act && (state_q == S_ONOFF) && ring_q &&
               (idx_q == ridx_q) && en_q[idx_q];

    if (MIN_TICK && hit) begin
      ring_d = 1'b1;
      ridx_d = hit_idx;
      cnt_d  = 8'd0;
    end else if (ring_q) begin
      if (ack || dis_ring) begin
        ring_d = 1'b0;
        cnt_d  = 8'd0;
      end else if (SEC_TICK) begin
        if (cnt_q == 8'(RING_SEC - 1)) begin
          ring_d = 1'b0;
          cnt_d  = 8'd0;
        end else begin
          cnt_d  = cnt_q + 8'd1;
        end
      end
    end

    case (state_d)
      S_SEL:   mode_d = 4'b1000;
      S_HOUR:  mode_d = 4'b0100;
      S_MIN:   mode_d = 4'b0010;
      S_ONOFF: mode_d = 4'b0001;
      default: mode_d = 4'b0000;
    endcase
  end

  // Single state register; edge detectors reset high so a held switch is ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      mode_q  <= 4'b0000;
      f1_q    <= 1'b1;
      f2_q    <= 1'b1;
      idx_q   <= '0;
      for (int k = 0; k < NUM_ALM; k++) begin
        hour_q[k] <= 5'(RST_HOUR);
        min_q[k]  <= 6'(RST_MIN);
      end
      en_q    <= '0;
      ring_q  <= 1'b0;
      ridx_q  <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      f1_q    <= SW_F1;
      f2_q    <= SW_F2;
      idx_q   <= idx_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      en_q    <= en_d;
      ring_q  <= ring_d;
      ridx_q  <= ridx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ALM_SELECT = mode_q[3];
  assign ALM_HOUR   = mode_q[2];
  assign ALM_MIN    = mode_q[1];
  assign ALM_ONOFF  = mode_q[0];
  assign ALM_IDX    = idx_q;
  assign SET_HOUR   = hour_q[idx_q];
  assign SET_MIN    = min_q[idx_q];
  assign ALM_EN     = en_q;
  assign RING       = ring_q;
  assign RING_IDX   = ridx_q;

endmodule

// File: tb/tb_alarm_ctrl_multi.sv
`timescale 1ns/1ps
// Bench for alarm_ctrl_multi: vector table for reset/navigation, hand sequences for edits and rings.
// Latency: expectations are queued per cycle and compared 1ns after the rising edge.
// Backpressure: none; the bench drives one stimulus cycle at a time.
module tb_alarm_ctrl_multi;

  localparam logic [3:0] M_IDLE  = 4'b0000;
  localparam logic [3:0] M_SEL   = 4'b1000;
  localparam logic [3:0] M_HOUR  = 4'b0100;
  localparam logic [3:0] M_MIN   = 4'b0010;
  localparam logic [3:0] M_ONOFF = 4'b0001;

  logic       CLK = 1'b0;
  logic       RST, SW_F1, SW_F2, SEC_TICK, MIN_TICK;
  logic [4:0] CUR_HOUR;
  logic [5:0] CUR_MIN;
  logic       ALM_SELECT, ALM_HOUR, ALM_MIN, ALM_ONOFF, RING;
  logic [1:0] ALM_IDX, RING_IDX;
  logic [4:0] SET_HOUR;
  logic [5:0] SET_MIN;
  logic [3:0] ALM_EN;

  always #5 CLK = ~CLK;

  alarm_ctrl_multi #(
    .NUM_ALM(4), .IDXW(2), .RST_HOUR(7), .RST_MIN(0), .RING_SEC(3)
  ) dut (
    .CLK(CLK), .RST(RST), .SW_F1(SW_F1), .SW_F2(SW_F2),
    .SEC_TICK(SEC_TICK), .MIN_TICK(MIN_TICK),
    .CUR_HOUR(CUR_HOUR), .CUR_MIN(CUR_MIN),
    .ALM_SELECT(ALM_SELECT), .ALM_HOUR(ALM_HOUR), .ALM_MIN(ALM_MIN),
    .ALM_ONOFF(ALM_ONOFF), .ALM_IDX(ALM_IDX), .SET_HOUR(SET_HOUR),
    .SET_MIN(SET_MIN), .ALM_EN(ALM_EN), .RING(RING), .RING_IDX(RING_IDX)
  );

  typedef struct packed {
    logic [3:0] mode;
    logic [1:0] idx;
    logic [4:0] sh;
    logic [5:0] sm;
    logic [3:0] en;
    logic       ring;
    logic [1:0] ridx;
  } exp_t;

  typedef struct {
    logic rst;
    logic f1;
    logic f2;
    exp_t e;
  } vec_t;

  vec_t  tbl[$];
  exp_t  sb_q[$];
  string nm_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  e;

  function automatic exp_t mk(logic [3:0] m, logic [1:0] i, logic [4:0] h,
                              logic [5:0] mi, logic [3:0] en, logic r, logic [1:0] ri);
    exp_t x;
    x.mode = m; x.idx = i; x.sh = h; x.sm = mi; x.en = en; x.ring = r; x.ridx = ri;
    return x;
  endfunction

  task automatic add(input logic rst, input logic f1, input logic f2,
                     input logic [3:0] m, input logic [1:0] i);
    vec_t v;
    v.rst = rst; v.f1 = f1; v.f2 = f2;
    v.e   = mk(m, i, 5'd7, 6'd0, 4'b0000, 1'b0, 2'd0);
    tbl.push_back(v);
  endtask

  task automatic check();
    exp_t  act, ex;
    string nm;
    act = {ALM_SELECT, ALM_HOUR, ALM_MIN, ALM_ONOFF, ALM_IDX, SET_HOUR,
           SET_MIN, ALM_EN, RING, RING_IDX};
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got output with no expectation queued");
    end else begin
      ex = sb_q.pop_front();
      nm = nm_q.pop_front();
      if (act !== ex) begin
        n_fail++;
        $display("FAIL %s: got mode=%b idx=%0d set=%0d:%0d en=%b ring=%b ridx=%0d, want mode=%b idx=%0d set=%0d:%0d en=%b ring=%b ridx=%0d",
                 nm, act.mode, act.idx, act.sh, act.sm, act.en, act.ring, act.ridx,
                 ex.mode, ex.idx, ex.sh, ex.sm, ex.en, ex.ring, ex.ridx);
      end
    end
  endtask

  // One clock: drive inputs, queue the expected outputs, compare after the edge.
  task automatic cyc(input logic f1, input logic f2, input logic sec,
                     input logic mt, input string nm);
    SW_F1 = f1; SW_F2 = f2; SEC_TICK = sec; MIN_TICK = mt;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge CLK);
    #1;
    check();
    SEC_TICK = 1'b0;
    MIN_TICK = 1'b0;
  endtask

  // Press then release; outputs must hold across the release cycle.
  task automatic press(input logic f1, input logic f2, input string nm);
    cyc(f1, f2, 1'b0, 1'b0, nm);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, {nm, "_rel"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; SW_F1 = 1'b1; SW_F2 = 1'b0; SEC_TICK = 1'b0; MIN_TICK = 1'b0;
    CUR_HOUR = 5'd0; CUR_MIN = 6'd0;

    // Reset with F1 held, held F1 ignored, then navigation and slot selection.
    add(1, 1, 0, M_IDLE, 0);  add(1, 1, 0, M_IDLE, 0);
    add(0, 1, 0, M_IDLE, 0);  add(0, 1, 0, M_IDLE, 0);  add(0, 1, 0, M_IDLE, 0);
    add(0, 0, 0, M_IDLE, 0);
    add(0, 1, 0, M_SEL, 0);   add(0, 0, 0, M_SEL, 0);
    add(0, 1, 0, M_HOUR, 0);  add(0, 0, 0, M_HOUR, 0);
    add(0, 1, 0, M_MIN, 0);   add(0, 0, 0, M_MIN, 0);
    add(0, 1, 0, M_ONOFF, 0); add(0, 0, 0, M_ONOFF, 0);
    add(0, 1, 0, M_IDLE, 0);  add(0, 0, 0, M_IDLE, 0);
    add(0, 1, 0, M_SEL, 0);   add(0, 0, 0, M_SEL, 0);
    add(0, 0, 1, M_SEL, 1);   add(0, 0, 0, M_SEL, 1);
    add(0, 0, 1, M_SEL, 2);   add(0, 0, 0, M_SEL, 2);
    add(0, 0, 1, M_SEL, 3);   add(0, 0, 0, M_SEL, 3);
    add(0, 0, 1, M_SEL, 0);   add(0, 0, 0, M_SEL, 0);

    foreach (tbl[i]) begin
      RST = tbl[i].rst;
      e   = tbl[i].e;
      cyc(tbl[i].f1, tbl[i].f2, 1'b0, 1'b0, $sformatf("vec%0d", i));
    end

    // Hour/minute wrap on slot 2; slots 3 and 0 untouched.
    e = mk(M_SEL, 0, 7, 0, 4'b0000, 0, 0);
    e.idx = 1; press(0, 1, "sel_idx1");
    e.idx = 2; press(0, 1, "sel_idx2");
    e.mode = M_HOUR; press(1, 0, "to_hour");
    for (int i = 1; i <= 17; i++) begin
      e.sh = 5'((7 + i) % 24);
      press(0, 1, $sformatf("hour_inc%0d", i));
    end
    e.mode = M_MIN; press(1, 0, "to_min");
    for (int i = 1; i <= 60; i++) begin
      e.sm = 6'(i % 60);
      press(0, 1, $sformatf("min_inc%0d", i));
    end
    e.mode = M_ONOFF; press(1, 0, "to_onoff");
    e.mode = M_IDLE;  press(1, 0, "to_idle");
    e.mode = M_SEL;   press(1, 0, "to_sel");
    e.idx = 3; e.sh = 7; e.sm = 0; press(0, 1, "slot3_7_00");
    e.idx = 0;                     press(0, 1, "slot0_7_00");

    // Slot 1 -> 7:01 enabled.
    e.idx = 1;        press(0, 1, "sel_slot1");
    e.mode = M_HOUR;  press(1, 0, "s1_hour");
    e.mode = M_MIN;   press(1, 0, "s1_min");
    e.sm = 1;         press(0, 1, "s1_min1");
    e.mode = M_ONOFF; press(1, 0, "s1_onoff");
    e.en = 4'b0010;   press(0, 1, "s1_enable");
    e.mode = M_IDLE;  press(1, 0, "s1_idle");
    // Slot 3 -> 7:01 enabled.
    e.mode = M_SEL;   press(1, 0, "s3_sel");
    e.idx = 2; e.sh = 0; e.sm = 0; press(0, 1, "sel_slot2");
    e.idx = 3; e.sh = 7; e.sm = 0; press(0, 1, "sel_slot3");
    e.mode = M_HOUR;  press(1, 0, "s3_hour");
    e.mode = M_MIN;   press(1, 0, "s3_min");
    e.sm = 1;         press(0, 1, "s3_min1");
    e.mode = M_ONOFF; press(1, 0, "s3_onoff");
    e.en = 4'b1010;   press(0, 1, "s3_enable");
    e.mode = M_IDLE;  press(1, 0, "s3_idle");

    // Ring, acknowledge, retrigger, F1+F2 together.
    CUR_HOUR = 5'd7; CUR_MIN = 6'd1;
    e.ring = 1; e.ridx = 1; cyc(0, 0, 0, 1, "trig_lowest");
    e.ring = 0;             press(0, 1, "ack_idle");
    e.ring = 1;             cyc(0, 0, 0, 1, "retrig");
    e.mode = M_SEL;         press(1, 1, "f1_f2_same");
    e.mode = M_HOUR;        press(1, 0, "ring_hour");
    e.mode = M_MIN;         press(1, 0, "ring_min");
    e.mode = M_ONOFF;       press(1, 0, "ring_onoff");
    e.mode = M_IDLE;        press(1, 0, "ring_idle");
    cyc(0, 1, 0, 1, "trig_beats_ack");
    cyc(0, 0, 0, 0, "trig_beats_ack_rel");

    // Timeout with counter restart on a new match.
    cyc(0, 0, 1, 0, "sec1");
    cyc(0, 0, 1, 0, "sec2");
    cyc(0, 0, 0, 1, "restart");
    cyc(0, 0, 1, 0, "sec1b");
    cyc(0, 0, 1, 0, "sec2b");
    e.ring = 0; cyc(0, 0, 1, 0, "timeout");

    // Disable the ringing slot in ONOFF mode.
    e.ring = 1; cyc(0, 0, 0, 1, "trig_s1");
    e.mode = M_SEL;                press(1, 0, "dis_sel");
    e.idx = 0; e.sh = 7; e.sm = 0; press(0, 1, "dis_idx0");
    e.idx = 1; e.sm = 1;           press(0, 1, "dis_idx1");
    e.mode = M_HOUR;               press(1, 0, "dis_hour");
    e.mode = M_MIN;                press(1, 0, "dis_min");
    e.mode = M_ONOFF;              press(1, 0, "dis_onoff");
    e.en = 4'b1000; e.ring = 0;    press(0, 1, "dis_clears_ring");
    e.ring = 1; e.ridx = 3;        cyc(0, 0, 0, 1, "trig_in_edit");
    e.en = 4'b1010;                press(0, 1, "enable_keeps_ring");
    e.en = 4'b1000;                press(0, 1, "dis_other_keeps_ring");
    cyc(0, 0, 1, 0, "sec1c");
    cyc(0, 0, 1, 0, "sec2c");
    e.ring = 0; cyc(0, 0, 1, 0, "timeout_c");

    // All slots disabled: a time match must not ring.
    e.mode = M_IDLE;               press(1, 0, "off_idle");
    e.mode = M_SEL;                press(1, 0, "off_sel");
    e.idx = 2; e.sh = 0; e.sm = 0; press(0, 1, "off_idx2");
    e.idx = 3; e.sh = 7; e.sm = 1; press(0, 1, "off_idx3");
    e.mode = M_HOUR;               press(1, 0, "off_hour");
    e.mode = M_MIN;                press(1, 0, "off_min");
    e.mode = M_ONOFF;              press(1, 0, "off_onoff");
    e.en = 4'b0000;                press(0, 1, "off_disable3");
    cyc(0, 0, 0, 1, "no_match_disabled");

    // Reset mid-edit and mid-ring.
    e.en = 4'b1000;        press(0, 1, "rr_enable3");
    e.ring = 1; e.ridx = 3; cyc(0, 0, 0, 1, "rr_trig");
    RST = 1'b1;
    e = mk(M_IDLE, 0, 7, 0, 4'b0000, 0, 0);
    cyc(0, 0, 0, 0, "reset_mid_ring");
    RST = 1'b0;
    cyc(0, 0, 0, 1, "post_rst_no_ring");
    e.mode = M_SEL; press(1, 0, "post_rst_sel");
    e.idx = 1;      press(0, 1, "slot1_reset_7_00");
    e.idx = 2;      press(0, 1, "slot2_reset_7_00");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
